alu_booth_seq: RTL and testbench

Radix-2 Booth multiply sequencer that time-shares the 16-bit ALU with the CPU datapath. When idle it forwards the CPU's ALU operands and function select unchanged. On a multiply request it takes over the ALU for 16 cycles. Each cycle it issues add, subtract or pass-x, then arithmetic-shifts the partial product, and returns a signed 32-bit product. It sits between the multicycle control unit and the ALU operand inputs.

---
 rtl/alu_booth_seq.sv | 152 +++++++++++++++
 tb/tb_alu_booth_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_booth_seq.sv
// Radix-2 Booth multiply sequencer that borrows the shared 16-bit ALU for 16 cycles per multiply.
// Optional high-half overflow flag is built only when ALU_MUL_HI_CHECK_EN is defined.
module alu_booth_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        ovf,
    input  logic [15:0] cpu_x,
    input  logic [15:0] cpu_y,
    input  logic [2:0]  cpu_fnsel,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_fnsel,
    input  logic [15:0] alu_z,
    input  logic        alu_cn,
    input  logic        alu_cn1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_PASS = 3'd6;

    state_e      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] a_q, a_d;
    logic [15:0] q_q, q_d;
    logic        q_1_q, q_1_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    logic        run;
    logic        add_sub;
    logic [2:0]  step_fn;
    logic [15:0] step_v;
    logic        step_s;
    logic [32:0] shifted;

    // The ALU result is only consumed on add/sub steps; a pass step keeps A as-is.
    always_comb begin
        run     = (state_q == RUN);
        add_sub = q_q[0] ^ q_1_q;
        unique case ({q_q[0], q_1_q})
            2'b01:   step_fn = FN_ADD;
            2'b10:   step_fn = FN_SUB;
            default: step_fn = FN_PASS;
        endcase
        step_v  = add_sub ? alu_z : a_q;
        // The true sign of the 17-bit sum is bit 15 flipped whenever the add/sub overflowed.
        step_s  = add_sub ? (alu_z[15] ^ (alu_cn ^ alu_cn1)) : a_q[15];
        shifted = {step_s, step_v, q_q};

        alu_x     = run ? a_q     : cpu_x;
        alu_y     = run ? m_q     : cpu_y;
        alu_fnsel = run ? step_fn : cpu_fnsel;
    end

`ifdef ALU_MUL_HI_CHECK_EN
    logic ovf_q, ovf_d;
`endif

    // NOTE: every next-state signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q_1_d     = q_1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef ALU_MUL_HI_CHECK_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = mcand;
                    a_d     = '0;
                    q_d     = mplier;
                    q_1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = shifted[32:17];
                q_d   = shifted[16:1];
                q_1_d = shifted[0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    product_d = shifted[32:1];
`ifdef ALU_MUL_HI_CHECK_EN
                    // Fits in signed 16 bits only if bits 31..15 are a pure sign extension.
                    ovf_d = !((&shifted[32:16]) || !(|shifted[32:16]));
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q_1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef ALU_MUL_HI_CHECK_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q_1_q     <= q_1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef ALU_MUL_HI_CHECK_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
`ifdef ALU_MUL_HI_CHECK_EN
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_booth_seq.sv
// Bench for alu_booth_seq: an ALU model closes the loop, and a transaction-level multiply model is checked every cycle.
module tb_alu_booth_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] mcand = '0;
    logic [15:0] mplier = '0;
    logic        ready, busy, done, ovf;
    logic [31:0] product;
    logic [15:0] cpu_x = 16'd5;
    logic [15:0] cpu_y = 16'd12;
    logic [2:0]  cpu_fnsel = 3'd0;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_fnsel;
    logic        alu_cn, alu_cn1;

    int n_vec = 0;
    int n_err = 0;

    alu_booth_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
        .ready(ready), .busy(busy), .done(done), .product(product), .ovf(ovf),
        .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_fnsel(cpu_fnsel),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fnsel(alu_fnsel),
        .alu_z(alu_z), .alu_cn(alu_cn), .alu_cn1(alu_cn1)
    );

    always #5 clk = ~clk;

    // Combinational ALU: sub is x + ~y + 1, carries taken out of bits 15 and 14.
    logic [15:0] alu_yy;
    logic        alu_cin;
    logic [16:0] alu_full;
    logic [15:0] alu_lo;
    always_comb begin
        alu_yy   = (alu_fnsel == 3'd1) ? ~alu_y : alu_y;
        alu_cin  = (alu_fnsel == 3'd1);
        alu_full = {1'b0, alu_x} + {1'b0, alu_yy} + {16'd0, alu_cin};
        alu_lo   = {1'b0, alu_x[14:0]} + {1'b0, alu_yy[14:0]} + {15'd0, alu_cin};
        alu_z    = '0;
        alu_cn   = 1'b0;
        alu_cn1  = 1'b0;
        case (alu_fnsel)
            3'd0, 3'd1: begin
                alu_z   = alu_full[15:0];
                alu_cn  = alu_full[16];
                alu_cn1 = alu_lo[15];
            end
            3'd2:    alu_z = alu_x & alu_y;
            3'd3:    alu_z = alu_x | alu_y;
            3'd5:    alu_z = alu_x - alu_y;
            3'd6:    alu_z = alu_x;
            default: alu_z = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hi_ovf(input logic [31:0] p);
`ifdef ALU_MUL_HI_CHECK_EN
        return !((p[31:15] == 17'h1FFFF) || (p[31:15] == 17'h0));
`else
        return 1'b0;
`endif
    endfunction

    // Transaction model: an accepted multiply owns the ALU for 16 cycles, then shows done for one.
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_product = '0;
    logic [31:0] m_exp = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_mcand = '0;
    logic signed [31:0] ext_a, ext_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_product = '0; m_ovf = 1'b0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_product = m_exp; m_ovf = hi_ovf(m_exp);
            end
        end else if (start) begin
            ext_a   = {{16{mcand[15]}}, mcand};
            ext_b   = {{16{mplier[15]}}, mplier};
            m_exp   = ext_a * ext_b;
            m_mcand = mcand;
            m_left  = 16;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            check("ready", {31'd0, ready}, {31'd0, (m_left == 0) && !m_done});
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("product", product, m_product);
            check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
            if (m_left > 0) begin
                check("alu_y_run", {16'd0, alu_y}, {16'd0, m_mcand});
                check("alu_fnsel_run", {31'd0, alu_fnsel inside {3'd0, 3'd1, 3'd6}}, 32'd1);
            end else begin
                check("alu_x_fwd", {16'd0, alu_x}, {16'd0, cpu_x});
                check("alu_y_fwd", {16'd0, alu_y}, {16'd0, cpu_y});
                check("alu_fnsel_fwd", {29'd0, alu_fnsel}, {29'd0, cpu_fnsel});
            end
        end
    end

    task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p, input logic exp_hi);
        int cyc;
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mcand = ~a; mplier = b ^ 16'h5A5A;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", cyc, 17);
        check("product_lit", product, exp_p);
        check("model_pin", m_product, exp_p);
`ifdef ALU_MUL_HI_CHECK_EN
        check("ovf_lit", {31'd0, ovf}, {31'd0, exp_hi});
`else
        check("ovf_lit", {31'd0, ovf}, {31'd0, 1'b0 & exp_hi});
`endif
        @(negedge clk);
    endtask

    initial begin
        int  cyc;
        int  n_done;
        bit  saw_done;
        logic [31:0] p_first, p_second;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_alu_x", {16'd0, alu_x}, 32'd5);
        check("rst_alu_y", {16'd0, alu_y}, 32'd12);
        check("rst_alu_fnsel", {29'd0, alu_fnsel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(16'd3, 16'd4, 32'h0000000C, 1'b0);
        do_mul(16'hFFFB, 16'd7, 32'hFFFFFFDD, 1'b0);
        do_mul(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1);
        do_mul(16'h8000, 16'h8000, 32'h40000000, 1'b1);

        // start held through a whole operation while the CPU keeps changing its ALU request.
        @(negedge clk);
        mcand = 16'd10; mplier = 16'hFFF7; start = 1'b1;
        n_done = 0; cyc = 0;
        p_first = '0; p_second = '0;
        while (n_done < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                mcand = 16'd100; mplier = 16'd3;
            end
            cpu_fnsel = 3'($urandom_range(0, 7));
            cpu_x     = 16'($urandom);
            if (done) begin
                n_done++;
                if (n_done == 1) p_first = product;
                else begin
                    p_second = product;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_two_done", n_done, 2);
        check("held_first", p_first, 32'hFFFFFFA6);
        check("held_second", p_second, 32'h0000012C);
        cpu_x = 16'd5; cpu_fnsel = 3'd0;
        repeat (2) @(negedge clk);

        // Asynchronous abort in the middle of a run.
        mcand = 16'd1234; mplier = 16'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_alu_x", {16'd0, alu_x}, {16'd0, cpu_x});
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        do_mul(16'd2, 16'hFFFD, 32'hFFFFFFFA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
